// File: rtl/servo_pos_demux_pwm.sv
// servo_pos_demux_pwm: routes 5-bit servo position words to one of two channels,
// holds them pending until the PWM frame boundary, then drives one PWM output per channel.
// Optional feature: define SERVO_CLAMP_EN to clamp accepted words to MAX_POS.
module servo_pos_demux_pwm #(
    parameter int unsigned WIDTH       = 5,
`ifdef SERVO_CLAMP_EN
    parameter int unsigned MAX_POS     = 28,
`endif
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned MIN_TICKS   = 1000,
    parameter int unsigned STEP_TICKS  = 32,
    parameter int unsigned FRAME_TICKS = 20000,
    parameter int unsigned RST_POS     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_sel_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             pwm0_o,
    output logic             pwm1_o,
    output logic [WIDTH-1:0] pos0_o,
    output logic [WIDTH-1:0] pos1_o,
    output logic             frame_start_o
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned TW = 15;
    localparam int unsigned NCH = 2;

    // Timebase state
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          frame_start_q, frame_start_d;

    // Per-channel pending slot, committed position and PWM output
    logic [NCH-1:0][WIDTH-1:0] pend_q, pend_d;
    logic [NCH-1:0]            flag_q, flag_d;
    logic [NCH-1:0][WIDTH-1:0] pos_q, pos_d;
    logic [NCH-1:0]            pwm_q, pwm_d;

    // Combinational helpers
    logic                   tick_c;
    logic                   commit_c;
    logic [NCH-1:0]         ready_c;
    logic [NCH-1:0]         accept_c;
    logic [WIDTH-1:0]       wdata_c;
    logic [NCH-1:0][TW-1:0] width_c;

    // Prescaler tick and frame-wrap detection
    always_comb begin
        tick_c   = (presc_q == PW'(CLK_DIV - 1));
        commit_c = tick_c && (frame_cnt_q == FW'(FRAME_TICKS - 1));
    end

    // Write-side word conditioning (end-stop clamp when enabled)
    always_comb begin
`ifdef SERVO_CLAMP_EN
        wdata_c = (in_data_i > WIDTH'(MAX_POS)) ? WIDTH'(MAX_POS) : in_data_i;
`else
        wdata_c = in_data_i;
`endif
    end

    // Per-channel readiness, accept qualification and pulse width
    always_comb begin
        ready_c  = '0;
        accept_c = '0;
        width_c  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            ready_c[ch]  = ~flag_q[ch] | commit_c;
            accept_c[ch] = in_valid_i && (in_sel_i == 1'(ch)) && ready_c[ch];
            width_c[ch]  = TW'(MIN_TICKS) + TW'(pos_q[ch]) * TW'(STEP_TICKS);
        end
    end

    // Ready for the currently selected channel; a full slot frees up on the commit edge
    assign in_ready_o = in_sel_i ? ready_c[1] : ready_c[0];

    // Next-state for timebase, routing, commit and PWM
    always_comb begin
        presc_d       = presc_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = commit_c;
        pend_d        = pend_q;
        flag_d        = flag_q;
        pos_d         = pos_q;
        pwm_d         = '0;

        if (tick_c) begin
            presc_d     = '0;
            frame_cnt_d = commit_c ? '0 : frame_cnt_q + FW'(1);
        end else begin
            presc_d     = presc_q + PW'(1);
        end

        for (int ch = 0; ch < NCH; ch++) begin
            // The old pending word always commits before a same-edge write lands
            if (commit_c && flag_q[ch]) begin
                pos_d[ch]  = pend_q[ch];
                flag_d[ch] = 1'b0;
            end
            if (accept_c[ch]) begin
                if (commit_c && !flag_q[ch]) begin
                    pos_d[ch]  = wdata_c;
                end else begin
                    pend_d[ch] = wdata_c;
                    flag_d[ch] = 1'b1;
                end
            end
            pwm_d[ch] = (TW'(frame_cnt_q) < width_c[ch]);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            pend_q        <= '0;
            flag_q        <= '0;
            pos_q         <= {NCH{WIDTH'(RST_POS)}};
            pwm_q         <= '0;
        end else begin
            presc_q       <= presc_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            pend_q        <= pend_d;
            flag_q        <= flag_d;
            pos_q         <= pos_d;
            pwm_q         <= pwm_d;
        end
    end

    // Output mapping
    assign pwm0_o        = pwm_q[0];
    assign pwm1_o        = pwm_q[1];
    assign pos0_o        = pos_q[0];
    assign pos1_o        = pos_q[1];
    assign frame_start_o = frame_start_q;

endmodule
